// File: rtl/pipe_rr_scheduler.sv
// pipe_rr_scheduler: round-robin issue of NREQ requesters into one shared
// fixed-latency pipeline, with credit-bounded in-flight beats and drain.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable, flush       scheduling enable (level), drain request (pulse)
//   req_valid/req_data  per-requester request, data packed i*WIDTH +: WIDTH
//   req_ready           one-hot grant (combinational)
//   pipe_in_*           registered issue beat (valid/data/tag)
//   pipe_out_*          pipeline result returning with its tag
//   rsp_valid/rsp_data  one-hot response valid, broadcast data
//   inflight, busy      credit usage, activity indicator
//   flush_done          one-cycle pulse when a drain completes
//   err_underflow       sticky: result returned with no credit in use
//
// Optional feature macro PIPE_SCHED_STATS_EN adds stats_clr and
// grant_count (one 16-bit saturating accept counter per requester).

module pipe_rr_scheduler #(
    parameter int  NREQ         = 4,
    parameter int  WIDTH        = 8,
    parameter int  MAX_INFLIGHT = 4,
    localparam int TAGW         = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  pipe_in_valid,
    output logic [WIDTH-1:0]      pipe_in_data,
    output logic [TAGW-1:0]       pipe_in_tag,
    input  logic                  pipe_out_valid,
    input  logic [WIDTH-1:0]      pipe_out_data,
    input  logic [TAGW-1:0]       pipe_out_tag,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [3:0]            inflight,
    output logic                  busy,
`ifdef PIPE_SCHED_STATS_EN
    input  logic                  stats_clr,
    output logic [NREQ*16-1:0]    grant_count,
`endif
    output logic                  flush_done,
    output logic                  err_underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [3:0] MAX_Q = 4'(MAX_INFLIGHT);

    state_e           state_q;
    logic             idle_fd_q;
    logic [TAGW-1:0]  rr_q;
    logic [TAGW-1:0]  rr_d;
    logic [3:0]       infl_q;
    logic [3:0]       infl_d;
    logic             err_q;
    logic             err_d;
    logic             pv_q;
    logic [WIDTH-1:0] pd_q;
    logic [TAGW-1:0]  pt_q;

    logic             grant_ok;
    logic [NREQ-1:0]  grant;
    logic [TAGW-1:0]  gidx;
    logic             accept;
    logic             drain_done;

    // ------------------------------------------------------------------
    // Grant: rotating priority search starting at the rr pointer.
    // ------------------------------------------------------------------
    always_comb begin
        int unsigned j;
        j        = 0;
        grant    = '0;
        gidx     = '0;
        accept   = 1'b0;
        grant_ok = (state_q == RUN) && (infl_q < MAX_Q);
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_q) + k) % NREQ;
            if (grant_ok && !accept && req_valid[j]) begin
                accept   = 1'b1;
                grant[j] = 1'b1;
                gidx     = TAGW'(j);
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Credits. A simultaneous issue and return cancel out; a return with
    // no credit outstanding is an error and leaves the count at zero.
    // ------------------------------------------------------------------
    always_comb begin
        infl_d = infl_q;
        err_d  = err_q;
        unique case ({accept, pipe_out_valid})
            2'b10: infl_d = infl_q + 4'd1;
            2'b01: begin
                if (infl_q == 4'd0) begin
                    err_d = 1'b1;
                end else begin
                    infl_d = infl_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM. idle_fd_q acknowledges a flush seen while idle one
    // cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idle_fd_q <= 1'b0;
        end else begin
            idle_fd_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (flush) begin
                        idle_fd_q <= 1'b1;
                    end else if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (flush || !enable) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (infl_d == 4'd0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The drain completion pulse lines up with the cycle that returns
    // the last credit, so it is decoded from the next credit count.
    assign drain_done = (state_q == DRAIN) && (infl_d == 4'd0);

    // ------------------------------------------------------------------
    // Datapath state: pointer, credits, error flag and issue register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q   <= '0;
            infl_q <= '0;
            err_q  <= 1'b0;
            pv_q   <= 1'b0;
            pd_q   <= '0;
            pt_q   <= '0;
        end else begin
            rr_q   <= rr_d;
            infl_q <= infl_d;
            err_q  <= err_d;
            pv_q   <= accept;
            if (accept) begin
                pd_q <= req_data[int'(gidx)*WIDTH +: WIDTH];
                pt_q <= gidx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Responses are routed by tag in every state; out-of-range tags
    // match no requester.
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = pipe_out_valid && (pipe_out_tag == TAGW'(i));
        end
    end

    assign rsp_data      = pipe_out_data;
    assign pipe_in_valid = pv_q;
    assign pipe_in_data  = pd_q;
    assign pipe_in_tag   = pt_q;
    assign inflight      = infl_q;
    assign busy          = (state_q != IDLE) || (infl_q != 4'd0);
    assign flush_done    = idle_fd_q | drain_done;
    assign err_underflow = err_q;

`ifdef PIPE_SCHED_STATS_EN
    logic [15:0] cnt_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stats_clr) begin
                    cnt_q[i] <= '0;
                end else if (grant[i] && cnt_q[i] != 16'hFFFF) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_count[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_pipe_rr_scheduler.sv
// tb_pipe_rr_scheduler: directed and randomized checks of pipe_rr_scheduler
// against a cycle-level reference model of the scheduling rules.

module tb_pipe_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int MAXI  = 4;
    localparam int TAGW  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic                  flush;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  pipe_in_valid;
    logic [WIDTH-1:0]      pipe_in_data;
    logic [TAGW-1:0]       pipe_in_tag;
    logic                  pipe_out_valid;
    logic [WIDTH-1:0]      pipe_out_data;
    logic [TAGW-1:0]       pipe_out_tag;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic [3:0]            inflight;
    logic                  busy;
    logic                  flush_done;
    logic                  err_underflow;
`ifdef PIPE_SCHED_STATS_EN
    logic                  stats_clr = 1'b0;
    logic [NREQ*16-1:0]    grant_count;
`endif

    pipe_rr_scheduler #(
        .NREQ        (NREQ),
        .WIDTH       (WIDTH),
        .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .pipe_in_valid (pipe_in_valid),
        .pipe_in_data  (pipe_in_data),
        .pipe_in_tag   (pipe_in_tag),
        .pipe_out_valid(pipe_out_valid),
        .pipe_out_data (pipe_out_data),
        .pipe_out_tag  (pipe_out_tag),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .inflight      (inflight),
        .busy          (busy),
`ifdef PIPE_SCHED_STATS_EN
        .stats_clr     (stats_clr),
        .grant_count   (grant_count),
`endif
        .flush_done    (flush_done),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // reference model state
    int         m_mode;
    int         m_infl;
    int         m_ptr;
    bit         m_err;
    bit         m_fidle;
    bit         m_pv;
    logic [7:0] m_pd;
    int         m_pt;
    int         last_acc;
    int         acc_cnt;
    bit         obs_fd;
    logic [3:0] obs_rdy;

    // emulated 2-cycle pipeline fed from the model's expected issue
    bit         auto_ret;
    bit         h1v, h2v;
    logic [7:0] h1d, h2d;
    int         h1t, h2t;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_mode = M_IDLE; m_infl = 0; m_ptr = 0; m_err = 0;
        m_fidle = 0; m_pv = 0; m_pd = '0; m_pt = 0;
        h1v = 0; h2v = 0; h1d = '0; h2d = '0; h1t = 0; h2t = 0;
        last_acc = -1;
    endtask

    // One clock cycle: inputs already applied; check, advance model, clock.
    task automatic step();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] er;
        int ni, j, ai;
        bit nerr, fd;
        if (auto_ret) begin
            pipe_out_valid = h2v;
            pipe_out_data  = h2d ^ 8'h5A;
            pipe_out_tag   = TAGW'(h2t);
        end
        #2;
        eg = '0;
        ai = -1;
        if (m_mode == M_RUN && m_infl < MAXI) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (ai < 0 && req_valid[j]) begin
                    ai = j;
                    eg[j] = 1'b1;
                end
            end
        end
        er = pipe_out_valid ? (4'b0001 << pipe_out_tag) : 4'b0000;
        ni = m_infl;
        nerr = m_err;
        if (ai >= 0 && !pipe_out_valid) ni = ni + 1;
        else if (ai < 0 && pipe_out_valid) begin
            if (ni == 0) nerr = 1;
            else ni = ni - 1;
        end
        fd = m_fidle || (m_mode == M_DRAIN && ni == 0);
        obs_fd  = flush_done;
        obs_rdy = req_ready;
        chk("req_ready", req_ready, eg);
        chk("rsp_valid", rsp_valid, er);
        chk("rsp_data", rsp_data, pipe_out_data);
        chk("pipe_in_valid", pipe_in_valid, m_pv);
        chk("pipe_in_data", pipe_in_data, m_pd);
        chk("pipe_in_tag", pipe_in_tag, m_pt);
        chk("inflight", inflight, m_infl);
        chk("busy", busy, (m_mode != M_IDLE) || (m_infl != 0));
        chk("flush_done", flush_done, fd);
        chk("err_underflow", err_underflow, m_err);
        m_fidle = (m_mode == M_IDLE) && flush;
        case (m_mode)
            M_IDLE:  if (!flush && enable) m_mode = M_RUN;
            M_RUN:   if (flush || !enable) m_mode = M_DRAIN;
            default: if (ni == 0) m_mode = M_IDLE;
        endcase
        h2v = h1v; h2d = h1d; h2t = h1t;
        h1v = m_pv; h1d = m_pd; h1t = m_pt;
        if (ai >= 0) begin
            m_pv = 1;
            m_pd = req_data[ai*WIDTH +: WIDTH];
            m_pt = ai;
            m_ptr = (ai + 1) % NREQ;
            acc_cnt = acc_cnt + 1;
        end else begin
            m_pv = 0;
        end
        last_acc = ai;
        m_infl = ni;
        m_err = nerr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int seq[$];
        int base, fdc, fdat, gaft;
        logic [NREQ-1:0] pend;
        rst_n = 0; enable = 0; flush = 0;
        req_valid = '0; req_data = '0;
        pipe_out_valid = 0; pipe_out_data = '0; pipe_out_tag = '0;
        auto_ret = 0; acc_cnt = 0; pend = '0;
        reset_model();
        #3;
        chk("rst_ready", req_ready, 0);
        chk("rst_pv", pipe_in_valid, 0);
        chk("rst_pd", pipe_in_data, 0);
        chk("rst_pt", pipe_in_tag, 0);
        chk("rst_infl", inflight, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", flush_done, 0);
        chk("rst_err", err_underflow, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;

        // round-robin over four continuous requesters
        enable = 1; req_valid = 4'hF; req_data = 32'h44332211; auto_ret = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (last_acc >= 0) seq.push_back(last_acc);
        end
        for (int i = 0; i < 8; i++) begin
            chk("rr_order", (seq.size() > i) ? seq[i] : -1, i % 4);
        end
        req_valid = '0;
        repeat (4) step();
        auto_ret = 0;
        pipe_out_valid = 0;

        // credit limit
        req_valid = 4'b0001; base = acc_cnt;
        repeat (8) step();
        chk("credit_accepts", acc_cnt - base, 4);
        chk("credit_full", inflight, 4);
        chk("credit_ready0", req_ready, 0);
        pipe_out_valid = 1; pipe_out_tag = 0; pipe_out_data = 8'h3C;
        step();
        pipe_out_valid = 0;
        repeat (4) step();
        chk("credit_one_more", acc_cnt - base, 5);

        // simultaneous issue/return, then underflow
        req_valid = '0; pipe_out_valid = 1;
        repeat (2) step();
        req_valid = 4'b0001;
        step();
        chk("same_cycle_infl", inflight, 2);
        req_valid = '0;
        repeat (2) step();
        chk("drained_infl", inflight, 0);
        step();
        pipe_out_valid = 0;
        chk("underflow_set", err_underflow, 1);
        repeat (3) step();
        chk("underflow_sticky", err_underflow, 1);

        // drain with three beats outstanding
        req_valid = 4'b0001;
        repeat (3) step();
        chk("pre_flush_infl", inflight, 3);
        req_valid = '0; flush = 1; enable = 0;
        step();
        flush = 0; req_valid = 4'hF;
        fdc = 0; fdat = -1; gaft = 0;
        for (int c = 0; c < 5; c++) begin
            pipe_out_valid = (c % 2 == 0);
            pipe_out_tag = 1;
            pipe_out_data = 8'(c);
            step();
            if (obs_fd) begin fdc = fdc + 1; fdat = c; end
            if (obs_rdy != 0) gaft = gaft + 1;
        end
        pipe_out_valid = 0; req_valid = '0;
        chk("drain_fd_count", fdc, 1);
        chk("drain_fd_cycle", fdat, 4);
        chk("drain_no_grant", gaft, 0);
        chk("drain_busy", busy, 0);
        step();

        // responses in IDLE, flush in IDLE
        pipe_out_valid = 1; pipe_out_tag = 2; pipe_out_data = 8'hA5;
        #1;
        chk("idle_rsp_valid", rsp_valid, 4'b0100);
        chk("idle_rsp_data", rsp_data, 8'hA5);
        step();
        pipe_out_valid = 0;
        flush = 1;
        step();
        flush = 0;
        chk("idle_flush_done", flush_done, 1);
        step();
        chk("idle_flush_once", flush_done, 0);

        // randomized traffic
        enable = 1; auto_ret = 1; pend = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i] = 1'b1;
                    req_data[i*WIDTH +: WIDTH] = 8'($urandom);
                end
            end
            req_valid = pend;
            flush = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 5) enable = ~enable;
            step();
            if (last_acc >= 0) pend[last_acc] = 1'b0;
        end

        // dense burst, then asynchronous reset in the middle of it
        flush = 0; enable = 1; pend = 4'hF; req_valid = pend;
        repeat (8) step();
        auto_ret = 0; pipe_out_valid = 0;
        pipe_out_data = '0; pipe_out_tag = '0;
        #2;
        rst_n = 0;
        #1;
        chk("async_ready", req_ready, 0);
        chk("async_pv", pipe_in_valid, 0);
        chk("async_pd", pipe_in_data, 0);
        chk("async_pt", pipe_in_tag, 0);
        chk("async_infl", inflight, 0);
        chk("async_busy", busy, 0);
        chk("async_fd", flush_done, 0);
        chk("async_err", err_underflow, 0);
        chk("async_rsp", rsp_valid, 0);
        enable = 0; req_valid = '0; pend = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        reset_model();
        @(posedge clk);
        #1;
        pipe_out_valid = 1; pipe_out_tag = 1; pipe_out_data = 8'h77;
        step();
        pipe_out_valid = 0;
        chk("late_underflow", err_underflow, 1);
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
